// File: rtl/uart_rx_deserializer.sv
// uart_rx_deserializer
// 8N1 UART receiver, LSB first. It synchronises the serial pin and checks the
// start bit at mid-bit. It then samples eight data bits and the stop bit, and
// hands each good byte to the RX buffer as a one-cycle write strobe.
// Framing errors and overruns are kept as sticky flags until err_clr_i.

module uart_rx_deserializer #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        rx_i,
  input  logic        buf_full_i,
  input  logic        err_clr_i,
  output logic        wr_en_o,
  output logic [31:0] wdata_o,
  output logic        busy_o,
  output logic        frame_err_o,
  output logic        overrun_o
);

  // Counter width. The maximum count is CLKS_PER_BIT-1, so $clog2 is enough.
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Start-bit validation point (mid-bit) and the last count of a full bit.
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          rx_s;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Two-flop synchroniser. It resets to the idle-high level, so a reset can never look like a start bit.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx_i};
    end
  end

  assign rx_s = sync[1];

  // Receive FSM. It owns the bit timing, the shift register, the write strobe and the sticky error flags.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= 3'd0;
      shreg       <= 8'h00;
      wr_en_o     <= 1'b0;
      wdata_o     <= 32'h0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      wr_en_o <= 1'b0;
      wdata_o <= 32'h0;

      if (err_clr_i) begin
        frame_err_o <= 1'b0;
        overrun_o   <= 1'b0;
      end

      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (baud_cnt == HALF_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            shreg    <= {rx_s, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        STOP: begin
          if (baud_cnt == FULL_LAST) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (buf_full_i) begin
                overrun_o <= 1'b1;
              end else begin
                wr_en_o <= 1'b1;
                wdata_o <= {24'h0, shreg};
              end
            end else begin
              frame_err_o <= 1'b1;
              state       <= WAIT_HI;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_ONE;
          end
        end

        WAIT_HI: begin
          baud_cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
        end
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// tb_uart_rx_deserializer
// Directed bench for the 8N1 receiver with CLKS_PER_BIT=8. A negedge monitor
// records every write strobe, and the test sequence checks those strobes
// against hand-computed bytes.

module tb_uart_rx_deserializer;

  localparam int CPB = 8;

  logic        clk;
  logic        rst_i;
  logic        rx_i;
  logic        buf_full_i;
  logic        err_clr_i;
  logic        wr_en_o;
  logic [31:0] wdata_o;
  logic        busy_o;
  logic        frame_err_o;
  logic        overrun_o;

  int          n_checks;
  int          n_fails;
  int          cycle;
  int          start_cycle;
  int          width_errs;
  int          idle_data_errs;
  logic        prev_wr;
  logic [31:0] strobe_data[$];
  int          strobe_cycle[$];

  uart_rx_deserializer #(.CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .rx_i        (rx_i),
    .buf_full_i  (buf_full_i),
    .err_clr_i   (err_clr_i),
    .wr_en_o     (wr_en_o),
    .wdata_o     (wdata_o),
    .busy_o      (busy_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count used for latency measurement
  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Strobe monitor: logs each strobe and flags wide strobes or nonzero idle data
  initial begin
    width_errs     = 0;
    idle_data_errs = 0;
    prev_wr        = 1'b0;
  end
  always @(negedge clk) begin
    if (wr_en_o === 1'b1) begin
      if (prev_wr) begin
        width_errs++;
      end else begin
        strobe_data.push_back(wdata_o);
        strobe_cycle.push_back(cycle);
      end
    end else if (wdata_o !== 32'h0) begin
      idle_data_errs++;
    end
    prev_wr = (wr_en_o === 1'b1);
  end

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fails++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives nbits of an 8N1 frame (start, 8 data bits LSB first, stop)
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input logic full_stop, input int nbits);
    logic [9:0] frame;
    frame = {stop_bit, data, 1'b0};
    start_cycle = cycle;
    for (int i = 0; i < nbits; i++) begin
      rx_i = frame[i];
      if (i == 9) buf_full_i = full_stop;
      waitCycles(CPB);
    end
    buf_full_i = 1'b0;
  endtask

  task automatic checkStrobe(input string tag, input logic [31:0] expected);
    if (strobe_data.size() == 0) begin
      checkOutput(tag, 32'hDEADBEEF, expected);
    end else begin
      checkOutput(tag, strobe_data.pop_front(), expected);
      void'(strobe_cycle.pop_front());
    end
  endtask

  initial begin
    int lat;
    n_checks   = 0;
    n_fails    = 0;
    rst_i      = 1'b1;
    rx_i       = 1'b1;
    buf_full_i = 1'b0;
    err_clr_i  = 1'b0;
    waitCycles(3);
    rst_i = 1'b0;
    waitCycles(1);

    // Reset state
    checkOutput("reset_wr_en", {31'b0, wr_en_o}, 32'd0);
    checkOutput("reset_wdata", wdata_o, 32'h0);
    checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("reset_frame_err", {31'b0, frame_err_o}, 32'd0);
    checkOutput("reset_overrun", {31'b0, overrun_o}, 32'd0);
    waitCycles(4);

    // 1. Nominal 0xA5 frame
    applyStimulus(8'hA5, 1'b1, 1'b0, 10);
    waitCycles(3);
    checkOutput("nominal_count", strobe_data.size(), 32'd1);
    if (strobe_cycle.size() > 0) begin
      lat = strobe_cycle[0] - start_cycle;
      checkOutput("nominal_latency_in_window", {31'b0, (lat >= 79 && lat <= 81)}, 32'd1);
    end
    checkStrobe("nominal_data", 32'h000000A5);
    checkOutput("nominal_frame_err", {31'b0, frame_err_o}, 32'd0);
    checkOutput("nominal_overrun", {31'b0, overrun_o}, 32'd0);
    checkOutput("nominal_busy_after", {31'b0, busy_o}, 32'd0);

    // 2. Three-cycle glitch is rejected at mid-bit
    start_cycle = cycle;
    rx_i = 1'b0;
    waitCycles(3);
    rx_i = 1'b1;
    waitCycles(2);
    checkOutput("glitch_busy_during", {31'b0, busy_o}, 32'd1);
    waitCycles(20);
    checkOutput("glitch_busy_after", {31'b0, busy_o}, 32'd0);
    checkOutput("glitch_no_strobe", strobe_data.size(), 32'd0);
    checkOutput("glitch_frame_err", {31'b0, frame_err_o}, 32'd0);
    checkOutput("glitch_overrun", {31'b0, overrun_o}, 32'd0);

    // 3. Stop bit low: framing error, then a line break held low
    applyStimulus(8'hA5, 1'b0, 1'b0, 10);
    waitCycles(2);
    checkOutput("frame_err_set", {31'b0, frame_err_o}, 32'd1);
    waitCycles(40);
    checkOutput("break_busy", {31'b0, busy_o}, 32'd1);
    checkOutput("break_no_strobe", strobe_data.size(), 32'd0);
    rx_i = 1'b1;
    waitCycles(5);
    checkOutput("break_release_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("frame_err_sticky", {31'b0, frame_err_o}, 32'd1);
    err_clr_i = 1'b1;
    waitCycles(1);
    err_clr_i = 1'b0;
    waitCycles(1);
    checkOutput("frame_err_cleared", {31'b0, frame_err_o}, 32'd0);

    // 4. Buffer full during the stop bit causes an overrun, then a good 0x3C
    applyStimulus(8'hA5, 1'b1, 1'b1, 10);
    waitCycles(3);
    checkOutput("overrun_set", {31'b0, overrun_o}, 32'd1);
    checkOutput("overrun_no_strobe", strobe_data.size(), 32'd0);
    applyStimulus(8'h3C, 1'b1, 1'b0, 10);
    waitCycles(3);
    checkOutput("after_overrun_count", strobe_data.size(), 32'd1);
    checkStrobe("after_overrun_data", 32'h0000003C);
    checkOutput("overrun_sticky", {31'b0, overrun_o}, 32'd1);

    // 5. Back-to-back frames with no idle gap
    applyStimulus(8'h00, 1'b1, 1'b0, 10);
    applyStimulus(8'hFF, 1'b1, 1'b0, 10);
    applyStimulus(8'h81, 1'b1, 1'b0, 10);
    waitCycles(3);
    checkOutput("b2b_count", strobe_data.size(), 32'd3);
    checkStrobe("b2b_first", 32'h00000000);
    checkStrobe("b2b_second", 32'h000000FF);
    checkStrobe("b2b_third", 32'h00000081);
    checkOutput("b2b_frame_err", {31'b0, frame_err_o}, 32'd0);

    // 6. Reset during bit 4 aborts the frame and clears the flags
    applyStimulus(8'hA5, 1'b1, 1'b0, 5);
    rx_i = 1'b0;
    waitCycles(4);
    rst_i = 1'b1;
    rx_i  = 1'b1;
    waitCycles(2);
    rst_i = 1'b0;
    waitCycles(30);
    checkOutput("rst_no_strobe", strobe_data.size(), 32'd0);
    checkOutput("rst_busy", {31'b0, busy_o}, 32'd0);
    checkOutput("rst_frame_err", {31'b0, frame_err_o}, 32'd0);
    checkOutput("rst_overrun", {31'b0, overrun_o}, 32'd0);
    applyStimulus(8'h5A, 1'b1, 1'b0, 10);
    waitCycles(3);
    checkOutput("post_rst_count", strobe_data.size(), 32'd1);
    checkStrobe("post_rst_data", 32'h0000005A);

    // Strobe shape over the whole run
    checkOutput("strobe_width", width_errs, 32'd0);
    checkOutput("wdata_zero_when_idle", idle_data_errs, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
